// File: rtl/lsq_pkg.sv
// lsq_pkg: shared load-store request types, default sizes and the round-robin pick helper
//   REQ_W      request payload width (wr + addr + data)
//   req_t      packed request {wr, addr[31:0], data[31:0]}
//   rr_pick()  first set bit of req_mask at or above rr_ptr, modulo num_ch; rr_ptr when none set
package lsq_pkg;
  localparam int REQ_W = 65;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_NUM_CH = 2;
  localparam int MAX_CH = 32;
  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;
  function automatic int rr_pick(input logic [MAX_CH-1:0] req_mask, input int rr_ptr, input int num_ch);
    int c;
    rr_pick = rr_ptr;
    for (int i = num_ch - 1; i >= 0; i--) begin
      c = (rr_ptr + i) % num_ch;
      if (req_mask[c]) rr_pick = c;
    end
  endfunction
endpackage

// File: rtl/req_ch_queue.sv
// req_ch_queue: single-channel request queue with fall-through head, level and almost_full
//   clk, rst_n         clock, async active-low reset (pointers only; storage is not reset)
//   flush              synchronous clear of both pointers
//   push / in_data     write one entry (caller guarantees space)
//   pop  / out_data    retire the head; out_data is a combinational read of the head
//   level, almost_full occupancy 0..DEPTH and level >= AFULL_LVL
module req_ch_queue import lsq_pkg::*; #(
  parameter int W = REQ_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AFULL_LVL = 3,
  localparam int PW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  in_data,
  output logic [W-1:0]  out_data,
  output logic [PW-1:0] level,
  output logic          almost_full
);
  localparam int AW = PW - 1;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [W-1:0]  mem [DEPTH];
  always_comb begin
    wr_ptr_d = flush ? '0 : wr_ptr_q + PW'(push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + PW'(pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr_q[AW-1:0]] <= in_data;
  end
  // Pointers carry one extra wrap bit so full and empty differ.
  assign level       = wr_ptr_q - rd_ptr_q;
  assign almost_full = level >= PW'(AFULL_LVL);
  assign out_data    = mem[rd_ptr_q[AW-1:0]];
endmodule

// File: rtl/request_fifo_mc.sv
// request_fifo_mc: NUM_CH request queues drained through one valid/ready port
//   clk, rst_n, flush                   clock, async active-low reset, sync clear of all queues
//   in_valid/in_data/in_ready           per-channel push ports (channel c at [c*DATA_WIDTH +: DATA_WIDTH])
//   out_valid/out_data/out_ch/out_ready merged output, granted channel index
//   level, almost_full                  per-channel occupancy and level >= AFULL_LVL
// Build option REQ_FIFO_MC_PRIO_EN: fixed priority (lowest channel wins) instead of round-robin.
module request_fifo_mc import lsq_pkg::*; #(
  parameter int DATA_WIDTH = REQ_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int AFULL_LVL = 3,
  localparam int CW = $clog2(NUM_CH),
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [NUM_CH-1:0]            in_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]            in_ready,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [CW-1:0]                out_ch,
  input  logic                         out_ready,
  output logic [NUM_CH*LW-1:0]         level,
  output logic [NUM_CH-1:0]            almost_full
);
  logic [NUM_CH-1:0]     push, pop, busy;
  logic [DATA_WIDTH-1:0] q_data [NUM_CH];
  logic [CW-1:0]         pick, lock_ch_q, lock_ch_d;
  logic                  lock_q, lock_d, fire;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    // in_ready looks only at the level, never at out_ready.
    assign in_ready[c] = (level[c*LW +: LW] != LW'(DEPTH)) && !flush;
    assign push[c]     = in_valid[c] && in_ready[c];
    assign pop[c]      = fire && (out_ch == CW'(c));
    assign busy[c]     = level[c*LW +: LW] != '0;
    req_ch_queue #(.W(DATA_WIDTH), .DEPTH(DEPTH), .AFULL_LVL(AFULL_LVL)) u_q (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .push        (push[c]),
      .pop         (pop[c]),
      .in_data     (in_data[c*DATA_WIDTH +: DATA_WIDTH]),
      .out_data    (q_data[c]),
      .level       (level[c*LW +: LW]),
      .almost_full (almost_full[c])
    );
  end
  assign out_valid = |busy;
  assign fire      = out_valid && out_ready;
  // A stalled offer keeps its channel until accepted.
  assign out_ch    = lock_q ? lock_ch_q : pick;
  assign out_data  = q_data[out_ch];
`ifdef REQ_FIFO_MC_PRIO_EN
  always_comb begin
    pick = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) if (busy[i]) pick = CW'(i);
  end
`else
  logic [CW-1:0] rr_ptr_q, rr_ptr_d;
  always_comb begin
    pick     = CW'(rr_pick(MAX_CH'(busy), int'(rr_ptr_q), NUM_CH));
    rr_ptr_d = flush ? '0 : !fire ? rr_ptr_q : (out_ch == CW'(NUM_CH - 1)) ? '0 : out_ch + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= '0;
    else rr_ptr_q <= rr_ptr_d;
  end
`endif
  always_comb begin
    lock_d    = !flush && out_valid && !out_ready;
    lock_ch_d = out_ch;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_ch_q <= lock_ch_d;
    end
  end
endmodule

// File: tb/tb_request_fifo_mc.sv
// tb_request_fifo_mc: directed checks of request_fifo_mc (2 channels, depth 4, round-robin build)
module tb_request_fifo_mc;
  import lsq_pkg::*;
  localparam int W = REQ_W;
  logic           clk = 1'b0;
  logic           rst_n, flush, out_valid, out_ready, out_ch;
  logic [1:0]     in_valid, in_ready, almost_full;
  logic [2*W-1:0] in_data;
  logic [W-1:0]   out_data;
  logic [5:0]     level;
  int             total = 0;
  int             bad = 0;
  always #5 clk = ~clk;
  request_fifo_mc #(.DATA_WIDTH(W), .DEPTH(4), .NUM_CH(2), .AFULL_LVL(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ch      (out_ch),
    .out_ready   (out_ready),
    .level       (level),
    .almost_full (almost_full)
  );
  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [W-1:0] pay(input logic [7:0] t);
    req_t r;
    r.wr   = t[0];
    r.addr = {24'h400000, t};
    r.data = {4{t}};
    return r;
  endfunction
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  localparam logic [7:0] T3_CH0 [4] = '{8'h10, 8'h20, 8'h11, 8'h21};
  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 2'b00; in_data = '0; out_ready = 1'b0;
    #12;
    check("rst_valid", out_valid, 0);
    check("rst_level", level, 0);
    check("rst_ready", in_ready, 2'b11);
    check("rst_afull", almost_full, 0);
    check("rst_ch", out_ch, 0);
    rst_n = 1'b1;
    tick;
    // fill ch0 to full, fifth push refused
    for (int k = 0; k < 5; k++) begin
      in_valid = 2'b01;
      in_data = {pay(8'hFF), pay(8'(k))};
      #1;
      check("fill_ready", in_ready[0], k < 4);
      tick;
      check("fill_level", level[2:0], (k < 4) ? k + 1 : 4);
      check("fill_afull", almost_full[0], k >= 2);
    end
    in_valid = 2'b00;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("drain_valid", out_valid, 1);
      check("drain_ch", out_ch, 0);
      check("drain_data", out_data, pay(8'(k)));
      tick;
    end
    #1;
    check("drain_empty", out_valid, 0);
    check("drain_level", level, 0);
    out_ready = 1'b0;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    // two entries on each channel, round-robin interleave
    in_valid = 2'b11;
    in_data = {pay(8'h20), pay(8'h10)};
    tick;
    in_data = {pay(8'h21), pay(8'h11)};
    tick;
    in_valid = 2'b00;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_ch", out_ch, k % 2);
      check("rr_data", out_data, pay(T3_CH0[k]));
      tick;
    end
    out_ready = 1'b0;
    // stalled grant on ch1 must hold after ch0 becomes non-empty
    in_valid = 2'b10;
    in_data = {pay(8'h22), pay(8'h00)};
    tick;
    in_valid = 2'b00;
    #1;
    check("hold_ch_a", out_ch, 1);
    check("hold_data_a", out_data, pay(8'h22));
    in_valid = 2'b01;
    in_data = {pay(8'h00), pay(8'h12)};
    tick;
    in_valid = 2'b00;
    #1;
    check("hold_ch_b", out_ch, 1);
    check("hold_data_b", out_data, pay(8'h22));
    check("hold_level", level, {3'd1, 3'd1});
    tick;
    check("hold_ch_c", out_ch, 1);
    check("hold_data_c", out_data, pay(8'h22));
    out_ready = 1'b1;
    tick;
    #1;
    check("hold_next_ch", out_ch, 0);
    check("hold_next_data", out_data, pay(8'h12));
    tick;
    #1;
    check("hold_empty", out_valid, 0);
    check("idle_ch_rr", out_ch, 1);
    out_ready = 1'b0;
    // full ch0: pop and push attempt in the same cycle
    for (int k = 0; k < 4; k++) begin
      in_valid = 2'b01;
      in_data = {pay(8'h00), pay(8'(8'h30 + k))};
      tick;
    end
    in_valid = 2'b00;
    #1;
    check("full_level", level[2:0], 4);
    check("full_ready", in_ready, 2'b10);
    in_valid = 2'b01;
    in_data = {pay(8'h00), pay(8'h34)};
    out_ready = 1'b1;
    #1;
    check("popfull_ready", in_ready[0], 0);
    check("popfull_data", out_data, pay(8'h30));
    tick;
    in_valid = 2'b00;
    out_ready = 1'b0;
    #1;
    check("popfull_level", level[2:0], 3);
    check("popfull_head", out_data, pay(8'h31));
    // levels 3/2 then flush with pushes on both channels
    for (int k = 0; k < 2; k++) begin
      in_valid = 2'b10;
      in_data = {pay(8'(8'h23 + k)), pay(8'h00)};
      tick;
    end
    #1;
    check("pre_flush_level", level, {3'd2, 3'd3});
    flush = 1'b1;
    in_valid = 2'b11;
    in_data = {pay(8'h25), pay(8'h35)};
    #1;
    check("flush_ready", in_ready, 2'b00);
    check("flush_valid", out_valid, 1);
    tick;
    flush = 1'b0;
    in_valid = 2'b00;
    #1;
    check("post_flush_level", level, 0);
    check("post_flush_valid", out_valid, 0);
    check("post_flush_ch", out_ch, 0);
    check("post_flush_afull", almost_full, 0);
    tick;
    check("post_flush_quiet", out_valid, 0);
    check("post_flush_ready", in_ready, 2'b11);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/request_fifo_mc.md
Name: request_fifo_mc

Overview:
- Multi-channel successor of the single request FIFO in the load-store subsystem.
- NUM_CH independent request queues of DEPTH entries each, one per requester (e.g. ch0 = load port, ch1 = store port).
- Queues drain through one valid/ready output port toward the memory interface, with round-robin arbitration.
- Adds per-channel fill level, almost-full flags and a synchronous flush.

Parameters:
- DATA_WIDTH, 65, request payload width: 1 wr + 32 addr + 32 data.
- DEPTH, 4, entries per channel; power of 2, >= 2.
- NUM_CH, 2, number of input channels; >= 2.
- AFULL_LVL, 3, per-channel level at which almost_full asserts; 1..DEPTH.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all queues.
- in_valid  in  NUM_CH  per-channel push request.
- in_data  in  NUM_CH*DATA_WIDTH  payloads; channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
- in_ready  out  NUM_CH  per-channel space available.
- out_valid  out  1  head request available.
- out_data  out  DATA_WIDTH  head payload of the granted channel.
- out_ch  out  $clog2(NUM_CH)  granted channel index.
- out_ready  in  1  consumer accepts.
- level  out  NUM_CH*($clog2(DEPTH)+1)  per-channel occupancy, 0..DEPTH.
- almost_full  out  NUM_CH  level >= AFULL_LVL.

Behaviour:
- Reset (async assert, state clears immediately):
  - Counts and pointers 0; rr_ptr 0; lock 0.
  - out_valid=0, out_ch=0, level=0, almost_full=0, in_ready=all 1.
  - Storage is not reset.
- Push on channel c: when in_valid[c] && in_ready[c].
  - in_ready[c] = (level[c] != DEPTH) && !flush.
  - No combinational path from out_ready to in_ready: a full channel refuses a push even if it pops in the same cycle.
- Pop: when out_valid && out_ready, from channel out_ch.
  - Simultaneous push and pop on the same channel: level unchanged, data order preserved.
- Latency: a push into an empty system gives out_valid=1 the next cycle (1-cycle latency). Output is fall-through; out_data is a combinational read of the head entry.
- Arbitration (when not locked): grant = first channel with level != 0, searching from rr_ptr upward modulo NUM_CH.
  - On each pop, rr_ptr <= (out_ch + 1) mod NUM_CH.
  - rr_ptr does not move without a pop.
- Stability rule: if out_valid && !out_ready, set lock.
  - While locked, out_ch and out_data hold unchanged until accepted, even if a higher-ranked channel becomes non-empty.
  - lock clears on pop.
- out_valid = OR of all (level != 0).
  - When out_valid=0, out_data is don't-care and out_ch = rr_ptr.
- Pointers are $clog2(DEPTH)+1 bits and wrap naturally; index with the low bits.
  - level = wr_ptr - rd_ptr per channel.
- flush=1:
  - Next edge clears all pointers, levels, rr_ptr and lock.
  - Pushes and pops in that cycle are discarded.
  - in_ready is forced 0 while flush is high; out_valid follows levels until the clear lands.
- Reset mid-transfer: all queued requests are lost; no partial state survives.

Optional Feature:
- Macro: REQ_FIFO_MC_PRIO_EN.
- Defined: arbitration is fixed priority, lowest channel index wins. rr_ptr is removed; the lock rule still applies.
- Undefined: round-robin as specified above.

Decomposition:
- Package lsq_pkg holds:
  - REQ_W=65 and the req_t packed struct {wr, addr[31:0], data[31:0]}.
  - Default DEPTH/NUM_CH constants.
  - Function rr_pick(req_mask, rr_ptr) returning the grant index.
- One sub-module, req_ch_queue: single-channel storage, pointers, level and almost_full, with push/pop/flush inputs.
- The top instantiates NUM_CH copies with a generate loop and holds the arbiter, lock and rr_ptr.

Test Plan:
- Reset then idle -> out_valid=0, level=0, in_ready=2'b11, almost_full=0.
- Push 4 entries on ch0 with out_ready=0 -> level0 goes 1,2,3,4; almost_full[0]=1 at level 3; in_ready[0]=0 at 4; 5th push is ignored; drain returns the data in order.
- ch0 and ch1 each hold 2 entries, out_ready=1 -> out_ch sequence 0,1,0,1 with the payloads in per-channel FIFO order.
- Hold out_ready=0 with ch1 granted, then push ch0 -> out_ch stays 1 and out_data is stable until out_ready=1.
- ch0 full, same-cycle pop of ch0 and push attempt on ch0 -> push rejected (in_ready[0]=0); level0 becomes 3.
- Levels 3/2, assert flush for 1 cycle together with in_valid=2'b11 -> next cycle levels 0, out_valid=0, and no pushed data appears.
